// File: rtl/reset_sequencer.sv
// reset_sequencer
//
// Power-on / soft-reset sequencer for the camera/video pipeline. Releases NUM_STAGES
// active-low resets one after another: stage 0 after INIT_DLY cycles, every later stage
// STAGE_DLY cycles after its predecessor. A level soft request (iREQ) seen while the
// sequence runs tears everything down, holds for HOLD_MIN cycles and re-runs the sequence.
//
// Optional feature, macro RSTSEQ_REVERSE_DRAIN_EN:
//   defined   - a soft request in RUN tears stages down highest index first, one per edge
//   undefined - a soft request in RUN drops every stage on the request edge
//
// Ports:
//   iCLK   in   1           sole clock
//   iRST   in   1           synchronous active-low reset, sampled on rising iCLK
//   iREQ   in   1           soft-reset request, level
//   oRST   out  NUM_STAGES  per-stage reset, 0 = held, 1 = released (registered)
//   oDONE  out  1           every stage released (registered)
//   oBUSY  out  1           sequencer not in RUN (registered)

module reset_sequencer #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CNT_W      = 22,
  parameter int unsigned INIT_DLY   = 2097151,
  parameter int unsigned STAGE_DLY  = 1048576,
  parameter int unsigned HOLD_MIN   = 16
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iREQ,
  output logic [NUM_STAGES-1:0] oRST,
  output logic                  oDONE,
  output logic                  oBUSY
);

  // idx must be able to step one past the last stage.
  localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] INIT_TC  = CNT_W'(INIT_DLY);
  localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_DLY);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_MIN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    StWait  = 2'd0,
    StRun   = 2'd1,
`ifdef RSTSEQ_REVERSE_DRAIN_EN
    StDrain = 2'd2,
`endif
    StHold  = 2'd3
  } state_e;

  state_e                  stateQ, stateD;
  logic [CNT_W-1:0]        cntQ, cntD;
  logic [IDX_W-1:0]        idxQ, idxD;
  logic [NUM_STAGES-1:0]   rstQ, rstD;
  logic                    doneQ, doneD;
  logic                    busyQ, busyD;

  logic [CNT_W-1:0]        cntInc;
  logic [CNT_W-1:0]        termCnt;

  // One-hot select of a stage; decoded by comparison so the index width never has to
  // match the log2 of the output width.
  function automatic logic [NUM_STAGES-1:0] stageMask(input logic [IDX_W-1:0] idx);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx == IDX_W'(k)) m[k] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    idxD    = idxQ;
    rstD    = rstQ;
    doneD   = doneQ;
    busyD   = busyQ;
    cntInc  = cntQ + 1'b1;
    termCnt = (idxQ == '0) ? INIT_TC : STAGE_TC;

    case (stateQ)
      StWait: begin
        if (iREQ) begin
          // Abort: drop whatever was released and restart after the hold.
          rstD   = '0;
          cntD   = '0;
          stateD = StHold;
        end else if (cntInc == termCnt) begin
          rstD = rstQ | stageMask(idxQ);
          cntD = '0;
          idxD = idxQ + 1'b1;
          if (idxQ == LAST_IDX) begin
            doneD  = 1'b1;
            busyD  = 1'b0;
            stateD = StRun;
          end
        end else begin
          cntD = cntInc;
        end
      end

      StRun: begin
        if (iREQ) begin
          doneD = 1'b0;
          busyD = 1'b1;
`ifdef RSTSEQ_REVERSE_DRAIN_EN
          // The request edge already clears the top stage.
          rstD = rstQ & ~stageMask(LAST_IDX);
          if (NUM_STAGES == 1) begin
            cntD   = '0;
            stateD = StHold;
          end else begin
            idxD   = LAST_IDX - 1'b1;
            stateD = StDrain;
          end
`else
          rstD   = '0;
          cntD   = '0;
          stateD = StHold;
`endif
        end
      end

`ifdef RSTSEQ_REVERSE_DRAIN_EN
      StDrain: begin
        rstD = rstQ & ~stageMask(idxQ);
        if (idxQ == '0) begin
          cntD   = '0;
          stateD = StHold;
        end else begin
          idxD = idxQ - 1'b1;
        end
      end
`endif

      StHold: begin
        if (cntInc == HOLD_TC) begin
          cntD   = '0;
          idxD   = '0;
          stateD = StWait;
        end else begin
          cntD = cntInc;
        end
      end

      default: begin
        stateD = StWait;
        cntD   = '0;
        idxD   = '0;
        rstD   = '0;
        doneD  = 1'b0;
        busyD  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      stateQ <= StWait;
      cntQ   <= '0;
      idxQ   <= '0;
      rstQ   <= '0;
      doneQ  <= 1'b0;
      busyQ  <= 1'b1;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      idxQ   <= idxD;
      rstQ   <= rstD;
      doneQ  <= doneD;
      busyQ  <= busyD;
    end
  end

  assign oRST  = rstQ;
  assign oDONE = doneQ;
  assign oBUSY = busyQ;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int INIT  = 8;
  localparam int STAGE = 4;
  localparam int HOLD  = 3;

  logic       clk = 1'b0;
  logic       iRST = 1'b0;
  logic       iREQ = 1'b0;
  logic [3:0] oRST4;
  logic       oDONE4, oBUSY4;
  logic [0:0] oRST1;
  logic       oDONE1, oBUSY1;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES(4), .CNT_W(8), .INIT_DLY(INIT), .STAGE_DLY(STAGE), .HOLD_MIN(HOLD)
  ) u_dut4 (
    .iCLK(clk), .iRST(iRST), .iREQ(iREQ), .oRST(oRST4), .oDONE(oDONE4), .oBUSY(oBUSY4)
  );

  reset_sequencer #(
    .NUM_STAGES(1), .CNT_W(8), .INIT_DLY(INIT), .STAGE_DLY(STAGE), .HOLD_MIN(HOLD)
  ) u_dut1 (
    .iCLK(clk), .iRST(iRST), .iREQ(iREQ), .oRST(oRST1), .oDONE(oDONE1), .oBUSY(oBUSY1)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [5:0] q4[$];
  logic [2:0] q1[$];
  int         qe4[$];
  int         qe1[$];

  // Timeline model: each instance is described by the edge its sequence (re)started
  // (seqStart) and, while tearing down, the edge of the request that began it.
  int edgeNo = 0;
  int seqStart[2];
  int tearEdge[2];
  bit tearDrain[2];
  int nStages[2] = '{4, 1};

  function automatic int relCount(int n, int t);
    int rel;
    if (t < INIT) return 0;
    rel = (t - INIT) / STAGE + 1;
    return (rel > n) ? n : rel;
  endfunction

  function automatic logic [5:0] expVec(int n, int e, int ss, int te, bit drain);
    logic [3:0] r;
    int cl;
    int rel;
    if (e < ss) begin
      r = '0;
      if (drain) begin
        cl = e - te + 1;
        if (cl > n) cl = n;
        r = 4'((1 << (n - cl)) - 1);
      end
      return {r, 1'b0, 1'b1};
    end
    rel = relCount(n, e - ss);
    r = 4'((1 << rel) - 1);
    return {r, (rel == n), (rel != n)};
  endfunction

  task automatic modelEdge(int i, bit rst, bit req);
    int n;
    n = nStages[i];
    if (!rst) begin
      seqStart[i]  = edgeNo;
      tearEdge[i]  = -1;
      tearDrain[i] = 1'b0;
    end else if (req && edgeNo > seqStart[i]) begin
      tearEdge[i] = edgeNo;
      if (relCount(n, edgeNo - 1 - seqStart[i]) == n) begin
`ifdef RSTSEQ_REVERSE_DRAIN_EN
        tearDrain[i] = 1'b1;
        seqStart[i]  = edgeNo + n - 1 + HOLD;
`else
        tearDrain[i] = 1'b0;
        seqStart[i]  = edgeNo + HOLD;
`endif
      end else begin
        tearDrain[i] = 1'b0;
        seqStart[i]  = edgeNo + HOLD;
      end
    end
  endtask

  task automatic step(bit rst, bit req, bit glitch);
    logic [5:0] v;
    @(negedge clk);
    iRST = rst;
    iREQ = req;
    edgeNo++;
    modelEdge(0, rst, req);
    modelEdge(1, rst, req);
    v = expVec(4, edgeNo, seqStart[0], tearEdge[0], tearDrain[0]);
    q4.push_back(v);
    qe4.push_back(edgeNo);
    v = expVec(1, edgeNo, seqStart[1], tearEdge[1], tearDrain[1]);
    q1.push_back({v[2], v[1], v[0]});
    qe1.push_back(edgeNo);
    @(posedge clk);
    if (glitch && rst) begin
      #3 iRST = 1'b0;
      #1 iRST = 1'b1;
    end
  endtask

  task automatic idle(int k);
    repeat (k) step(1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are registered, so every edge presents a result.
  initial begin
    logic [5:0] e4, a4;
    logic [2:0] e1, a1;
    int         ed;
    forever begin
      @(posedge clk);
      #2;
      if (q4.size() > 0) begin
        e4 = q4.pop_front();
        ed = qe4.pop_front();
        a4 = {oRST4, oDONE4, oBUSY4};
        compared++;
        if (a4 !== e4) begin
          mismatched++;
          $display("FAIL stages4 edge %0d: got rst/done/busy=%b want %b", ed, a4, e4);
        end
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        ed = qe1.pop_front();
        a1 = {oRST1, oDONE1, oBUSY1};
        compared++;
        if (a1 !== e1) begin
          mismatched++;
          $display("FAIL stages1 edge %0d: got rst/done/busy=%b want %b", ed, a1, e1);
        end
      end
    end
  end

  initial begin
    seqStart  = '{0, 0};
    tearEdge  = '{-1, -1};
    tearDrain = '{1'b0, 1'b0};

    // Power-on then soft request at relative edge 30.
    repeat (3) step(1'b0, 1'b0, 1'b0);
    idle(29);
    step(1'b1, 1'b1, 1'b0);
    idle(40);

    // Abort mid-sequence at relative edge 14.
    step(1'b0, 1'b0, 1'b0);
    idle(13);
    step(1'b1, 1'b1, 1'b0);
    idle(40);

    // Reset mid-drain, then sub-cycle glitches on iRST.
    step(1'b0, 1'b0, 1'b0);
    idle(29);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (30) step(1'b1, 1'b0, 1'b1);

    // Random soft requests, resets and glitches.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 49) == 0));
    end
    idle(2);

    #30;
    compared++;
    if (q4.size() != 0 || q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain_queues: got %0d/%0d pending want 0/0", q4.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
